// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 core front end.
// The entry layout is fixed at 32-bit fields to match the RV32 datapath.
package core_pkg;

    typedef struct packed {
        int unsigned xlen;
        logic [31:0] bootrom_base;
    } config_t;

    localparam config_t CORE_CFG = '{xlen: 32, bootrom_base: 32'h8000_0000};

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush and push in the
// same cycle leave exactly the pushed entry buffered.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_slot;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (flush || !full);
    assign do_pop  = pop && !empty && !flush;
    assign wr_slot = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? ptr_inc('0) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_slot] <= push_data;
    end

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers in-order responses and handles redirects and faults.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | issuing requests while credit is available
//   HALT  | fault seen; no requests, buffer drains, wait for redirect
module core_fetch
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_CFG.xlen,
    parameter logic [XLEN-1:0] RESET_PC = CORE_CFG.bootrom_base,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_fault
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_flush, fifo_push, fifo_full, fifo_empty;
    logic            if_fire, req_fire, credit;
    fetch_entry_t    push_entry, head_entry;

    // An entry leaving this cycle frees its slot for a request this cycle,
    // which is what lets DEPTH = latency + 1 sustain one fetch per cycle.
    assign if_fire = !fifo_empty && if_ready;
    assign credit  = (outstanding_q + fifo_count - CW'(if_fire)) < CW'(DEPTH);
    assign imem_req_addr = fetch_pc_q & FETCH_ALIGN_MASK;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        pc_d           = pc_q;
        discard_d      = discard_q;
        fifo_flush     = 1'b0;
        fifo_push      = 1'b0;
        push_entry     = '0;
        imem_req_valid = 1'b0;

        if (state_q == RUN && !rst) imem_req_valid = credit && !redirect_valid;
        req_fire = imem_req_valid && imem_req_ready;
        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc;
            pc_d       = redirect_pc;
            state_d    = RUN;
            if (|(redirect_pc & ~FETCH_ALIGN_MASK)) begin
                fifo_push  = 1'b1;
                push_entry = '{pc: redirect_pc, inst: '0, fault: 1'b1};
                state_d    = HALT;
            end
        end else if (imem_rsp_valid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end else if (!fifo_full) begin
                fifo_push  = 1'b1;
                push_entry = '{pc: pc_q, inst: imem_rsp_err ? '0 : imem_rsp_data,
                               fault: imem_rsp_err};
                pc_d       = pc_q + XLEN'(4);
                if (imem_rsp_err) begin
                    state_d   = HALT;
                    discard_d = outstanding_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .pop       (if_fire),
        .push_data (push_entry),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = fifo_empty ? '0 : head_entry.pc;
    assign if_inst  = fifo_empty ? '0 : head_entry.inst;
    assign if_fault = !fifo_empty && head_entry.fault;

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch with a latency-configurable in-order memory.
module tb_core_fetch;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;

    always #5 clk = ~clk;

    core_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    logic        dlv_fault[$];
    int          dlv_cyc[$];
    int          cyc_n = 0;
    int          mem_lat = 1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h1234_0000;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        dlv_pc.delete();
        dlv_inst.delete();
        dlv_fault.delete();
        dlv_cyc.delete();
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cyc(input logic redir = 1'b0, input logic [31:0] rpc = '0);
        mem_req_t m;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(m.addr);
            imem_rsp_err   = err_en && (m.addr == err_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_rsp_err   = 1'b0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc_n + mem_lat;
            mem_q.push_back(m);
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc_n);
        end
        if (if_valid && if_ready) begin
            dlv_pc.push_back(if_pc);
            dlv_inst.push_back(if_inst);
            dlv_fault.push_back(if_fault);
            dlv_cyc.push_back(cyc_n);
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic restart(input int lat);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        repeat (2) @(negedge clk);
        mem_q.delete();
        clear_logs();
        cyc_n   = 0;
        mem_lat = lat;
        err_en  = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // reset state
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_fault", 32'(if_fault), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        @(negedge clk);

        // streaming, 1-cycle memory
        restart(1);
        if_ready = 1'b1;
        repeat (10) cyc();
        chk("t1_nreq", 32'(req_log.size()), 32'd10);
        chk("t1_first_req_cyc", 32'(req_cyc[0]), 32'd0);
        for (int i = 0; i < req_log.size(); i++)
            chk("t1_req_addr", req_log[i], 32'h8000_0000 + 32'(4 * i));
        chk("t1_ndlv", 32'(dlv_pc.size()), 32'd8);
        for (int i = 0; i < dlv_pc.size(); i++) begin
            chk("t1_dlv_cyc", 32'(dlv_cyc[i]), 32'(2 + i));
            chk("t1_dlv_pc", dlv_pc[i], 32'h8000_0000 + 32'(4 * i));
            chk("t1_dlv_inst", dlv_inst[i], inst_of(32'h8000_0000 + 32'(4 * i)));
        end

        // decode back-pressure
        restart(1);
        if_ready = 1'b0;
        repeat (10) cyc();
        chk("t2_nreq_stalled", 32'(req_log.size()), 32'd2);
        chk("t2_if_valid_stalled", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        repeat (6) cyc();
        chk("t2_ndlv", 32'(dlv_pc.size()), 32'd6);
        for (int i = 0; i < dlv_pc.size(); i++) begin
            chk("t2_dlv_pc", dlv_pc[i], 32'h8000_0000 + 32'(4 * i));
            chk("t2_dlv_inst", dlv_inst[i], inst_of(32'h8000_0000 + 32'(4 * i)));
        end

        // redirect with two requests in flight, 3-cycle memory
        restart(3);
        if_ready = 1'b1;
        cyc();
        cyc();
        chk("t3_nreq_before", 32'(req_log.size()), 32'd2);
        cyc(1'b1, 32'h8000_0100);
        repeat (15) cyc();
        chk("t3_req_after", req_log[2], 32'h8000_0100);
        chk("t3_dlv0_pc", dlv_pc[0], 32'h8000_0100);
        chk("t3_dlv0_inst", dlv_inst[0], inst_of(32'h8000_0100));
        chk("t3_dlv0_fault", 32'(dlv_fault[0]), 32'd0);
        chk("t3_dlv1_pc", dlv_pc[1], 32'h8000_0104);

        // misaligned redirect, then recovery
        restart(1);
        if_ready = 1'b1;
        repeat (3) cyc();
        cyc(1'b1, 32'h8000_0102);
        clear_logs();
        repeat (6) cyc();
        chk("t4_nreq_halt", 32'(req_log.size()), 32'd0);
        chk("t4_ndlv", 32'(dlv_pc.size()), 32'd1);
        chk("t4_fault_pc", dlv_pc[0], 32'h8000_0102);
        chk("t4_fault_inst", dlv_inst[0], 32'd0);
        chk("t4_fault_flag", 32'(dlv_fault[0]), 32'd1);
        cyc(1'b1, 32'h8000_0200);
        clear_logs();
        base = cyc_n;
        repeat (6) cyc();
        chk("t4_resume_req_cyc", 32'(req_cyc[0] - base), 32'd0);
        chk("t4_resume_req", req_log[0], 32'h8000_0200);
        chk("t4_resume_pc", dlv_pc[0], 32'h8000_0200);
        chk("t4_resume_inst", dlv_inst[0], inst_of(32'h8000_0200));

        // access fault on the third response
        restart(1);
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        if_ready = 1'b1;
        repeat (10) cyc();
        chk("t5_nreq", 32'(req_log.size()), 32'd4);
        chk("t5_ndlv", 32'(dlv_pc.size()), 32'd3);
        chk("t5_dlv0_fault", 32'(dlv_fault[0]), 32'd0);
        chk("t5_dlv1_fault", 32'(dlv_fault[1]), 32'd0);
        chk("t5_dlv2_pc", dlv_pc[2], 32'h8000_0008);
        chk("t5_dlv2_inst", dlv_inst[2], 32'd0);
        chk("t5_dlv2_fault", 32'(dlv_fault[2]), 32'd1);

        // asynchronous reset with entries buffered
        restart(1);
        if_ready = 1'b0;
        repeat (5) cyc();
        chk("t6_if_valid_pre", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        #1;
        chk("t6_req_valid_pre", 32'(imem_req_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_if_valid_rst", 32'(if_valid), 32'd0);
        chk("t6_req_valid_rst", 32'(imem_req_valid), 32'd0);
        chk("t6_if_pc_rst", if_pc, 32'd0);
        restart(1);
        if_ready = 1'b1;
        repeat (4) cyc();
        chk("t6_restart_req", req_log[0], 32'h8000_0000);
        chk("t6_restart_cyc", 32'(req_cyc[0]), 32'd0);
        chk("t6_restart_dlv", dlv_pc[0], 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
